// File: rtl/pkt_gen_pkg.sv
// pkt_gen_pkg: shared types, LFSR taps and step function for the packet generator
package pkt_gen_pkg;
  typedef enum logic [1:0] {MODE_FIXED = 2'd0, MODE_INCR = 2'd1, MODE_RANDOM = 2'd2} pay_mode_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd2} state_e;
  typedef struct packed {
    logic       eop;
    logic [7:0] payload;
    logic [1:0] ptype;
    logic [1:0] dest;
  } pkt_fields_t;
  // x^16 + x^14 + x^13 + x^11 + 1 expressed as state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/pkt_gen_param_lfsr.sv
// pkt_lfsr: 16-bit Fibonacci LFSR stepping once per advance, state replicated to OUT_W bits
module pkt_lfsr
  import pkt_gen_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [OUT_W-1:0] value
);
  logic [15:0] state;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= SEED;
    else if (advance) state <= lfsr_next(state);
  always_comb begin
    value = '0;
    for (int i = 0; i < OUT_W; i++) value[i] = state[i % 16];
  end
endmodule

// File: rtl/pkt_gen_param.sv
// pkt_gen_param: multi-beat packet generator over valid/ready with optional inter-packet gap
// PKTGEN_STATS_EN adds per-destination saturating EOP counters on stat_dest_cnt
module pkt_gen_param
  import pkt_gen_pkg::*;
#(
  parameter int          DEST_W    = 2,
  parameter int          TYPE_W    = 2,
  parameter int          DATA_W    = 8,
  parameter int          MAX_BEATS = 8,
  parameter int          IPG       = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16,
  localparam int         LEN_W     = $clog2(MAX_BEATS + 1),
  localparam int         PKT_W     = 1 + DATA_W + TYPE_W + DEST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_dest_rand,
  input  logic [DEST_W-1:0] cfg_dest,
  input  logic [TYPE_W-1:0] cfg_type,
  input  logic [DATA_W-1:0] cfg_payload,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              ready,
  output logic              valid,
  output logic [PKT_W-1:0]  packet,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_count
`ifdef PKTGEN_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_dest_cnt [2**DEST_W]
`endif
);
  localparam int R_W = DATA_W > DEST_W ? DATA_W : DEST_W;
  localparam int G_W = $clog2(IPG + 2);
  localparam logic [G_W-1:0] GAP_LAST = G_W'(IPG > 0 ? IPG - 1 : 0);
  state_e state, state_nx;
  pay_mode_e mode_q;
  logic [LEN_W-1:0] len_q, beat_q;
  logic [DEST_W-1:0] dest_q;
  logic [TYPE_W-1:0] type_q;
  logic [DATA_W-1:0] pay_q;
  logic [G_W-1:0] gap_q;
  logic [R_W-1:0] rbits;
  logic xfer, last, eop_xfer, gap_done, start;
  pkt_lfsr #(.SEED(LFSR_SEED), .OUT_W(R_W)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (xfer),
    .value   (rbits)
  );
  assign valid = state == ST_SEND;
  assign busy = state != ST_IDLE;
  assign packet = valid ? {last, mode_q == MODE_RANDOM ? rbits[DATA_W-1:0] : pay_q, type_q, dest_q} : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  // a new packet may start from IDLE, straight after EOP (no gap) or at the end of the gap
  always_comb begin
    xfer = valid && ready;
    last = beat_q == len_q;
    eop_xfer = xfer && last;
    gap_done = state == ST_GAP && gap_q == GAP_LAST;
    start = enable && (state == ST_IDLE || (eop_xfer && IPG == 0) || gap_done);
    state_nx = start ? ST_SEND :
               eop_xfer ? (IPG > 0 ? ST_GAP : ST_IDLE) :
               gap_done ? ST_IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mode_q <= MODE_FIXED;
      len_q <= '0;
      beat_q <= '0;
      dest_q <= '0;
      type_q <= '0;
      pay_q <= '0;
      gap_q <= '0;
      pkt_count <= '0;
    end else begin
      if (start) begin
        mode_q <= cfg_mode == 2'd3 ? MODE_FIXED : pay_mode_e'(cfg_mode);
        len_q <= cfg_len == '0 ? LEN_W'(1) : cfg_len > LEN_W'(MAX_BEATS) ? LEN_W'(MAX_BEATS) : cfg_len;
        beat_q <= LEN_W'(1);
        dest_q <= cfg_dest_rand ? rbits[DEST_W-1:0] : cfg_dest;
        type_q <= cfg_type;
        pay_q <= cfg_payload;
      end else if (xfer) begin
        beat_q <= beat_q + LEN_W'(1);
        pay_q <= mode_q == MODE_INCR ? pay_q + DATA_W'(1) : pay_q;
      end
      gap_q <= state == ST_GAP ? gap_q + G_W'(1) : '0;
      if (eop_xfer) pkt_count <= pkt_count + CNT_W'(1);
    end
`ifdef PKTGEN_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int d = 0; d < 2**DEST_W; d++) stat_dest_cnt[d] <= '0;
    end else if (eop_xfer && stat_dest_cnt[dest_q] != '1) begin
      stat_dest_cnt[dest_q] <= stat_dest_cnt[dest_q] + CNT_W'(1);
    end
`endif
endmodule
